// File: rtl/enc_fifo_sequencer_pkg.sv
// ============================================================================
// Module      : enc_pkg (package)
// Description : Shared encodings and sizing helpers for the encoder staging
//               FIFO burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

    // Default staging FIFO capacity in entries
    localparam int ENC_DEPTH_DEFAULT = 16;

    // Sequencer state encodings (2 bits, legacy-compatible constants)
    typedef logic [1:0] seq_state_t;
    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_FILL  = 2'd1;
    localparam logic [1:0] SEQ_DRAIN = 2'd2;
    localparam logic [1:0] SEQ_DONE  = 2'd3;

    // Counter width able to hold the value DEPTH itself
    function automatic int enc_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/enc_fifo_sequencer_burst_counter.sv
// ============================================================================
// Module      : enc_burst_counter
// Description : Burst beat counter with synchronous clear, increment and a
//               terminal-count flag raised on the last beat of the burst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_burst_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             at_last
);

    logic [CNT_W-1:0] r_count;

    // Count accepted beats; clear has priority over increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Last beat: the current beat index equals term-1
    assign at_last = (r_count == (term - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/enc_fifo_sequencer.sv
// ============================================================================
// Module      : enc_fifo_sequencer
// Description : Burst controller for the encoder staging FIFO. Latches a
//               burst length, fills the FIFO with that many writes, drains
//               the same number of reads, pulses done and re-arms.
//               Optional macro ENC_FIFO_SEQ_ABORT_EN adds abort/flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_fifo_sequencer
    import enc_pkg::*;
#(
    parameter int DEPTH = ENC_DEPTH_DEFAULT,
    parameter int CNT_W = enc_cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             src_valid,
    input  logic             dst_ready,
`ifdef ENC_FIFO_SEQ_ABORT_EN
    input  logic             abort,
    output logic             flush,
`endif
    output logic             we,
    output logic             re,
    output logic [CNT_W-1:0] level,
    output logic             busy,
    output logic             done,
    output logic             len_err
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [CNT_W-1:0] r_len_q;
    logic [CNT_W-1:0] r_level;
    logic             r_len_err;
    logic             r_done;
    logic             w_start_ok;
    logic             w_abort;
    logic             w_cnt_clear;
    logic             w_wr_last;
    logic             w_rd_last;

    assign w_start_ok = (r_state == SEQ_IDLE) && start;

`ifdef ENC_FIFO_SEQ_ABORT_EN
    logic r_flush;

    // abort only acts while a burst is in flight
    assign w_abort = abort && ((r_state == SEQ_FILL) || (r_state == SEQ_DRAIN));

    // One-cycle flush pulse following an accepted abort
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_abort;
        end
    end

    assign flush = r_flush;
`else
    assign w_abort = 1'b0;
`endif

    // FIFO enables decode from state, so they are mutually exclusive
    assign we   = (r_state == SEQ_FILL)  && src_valid;
    assign re   = (r_state == SEQ_DRAIN) && dst_ready;
    assign busy = (r_state == SEQ_FILL)  || (r_state == SEQ_DRAIN);

    assign w_cnt_clear = (r_state == SEQ_DONE) || w_abort;

    enc_burst_counter #(
        .CNT_W (CNT_W)
    ) u_wr_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_cnt_clear),
        .inc     (we),
        .term    (r_len_q),
        .at_last (w_wr_last)
    );

    enc_burst_counter #(
        .CNT_W (CNT_W)
    ) u_rd_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_cnt_clear),
        .inc     (re),
        .term    (r_len_q),
        .at_last (w_rd_last)
    );

    // Next-state decode; an abort overrides any completion this cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            SEQ_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? SEQ_DONE : SEQ_FILL;
                end
            end
            SEQ_FILL: begin
                if (we && w_wr_last) begin
                    w_next = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (re && w_rd_last) begin
                    w_next = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                w_next = SEQ_IDLE;
            end
            default: begin
                w_next = SEQ_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next = SEQ_IDLE;
        end
    end

    // State register; done is registered so it is high exactly while in DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SEQ_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == SEQ_DONE);
        end
    end

    // Latch the clamped burst length and the over-length flag on accepted start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len_q   <= '0;
            r_len_err <= 1'b0;
        end else if (w_start_ok) begin
            r_len_q   <= (len > c_depth) ? c_depth : len;
            r_len_err <= (len > c_depth);
        end
    end

    // FIFO occupancy: +1 per write, -1 per read, zeroed by abort
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else if (w_abort) begin
            r_level <= '0;
        end else if (we) begin
            r_level <= r_level + CNT_W'(1);
        end else if (re) begin
            r_level <= r_level - CNT_W'(1);
        end
    end

    assign level   = r_level;
    assign done    = r_done;
    assign len_err = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_enc_fifo_sequencer.sv
// ============================================================================
// Module      : tb_enc_fifo_sequencer
// Description : Directed self-checking bench for enc_fifo_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enc_fifo_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic [4:0] len;
    logic       src_valid;
    logic       dst_ready;
    logic       we;
    logic       re;
    logic [4:0] level;
    logic       busy;
    logic       done;
    logic       len_err;
`ifdef ENC_FIFO_SEQ_ABORT_EN
    logic       abort;
    logic       flush;
`endif

    int checks   = 0;
    int failures = 0;

    enc_fifo_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .src_valid (src_valid),
        .dst_ready (dst_ready),
`ifdef ENC_FIFO_SEQ_ABORT_EN
        .abort     (abort),
        .flush     (flush),
`endif
        .we        (we),
        .re        (re),
        .level     (level),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Run one burst with both handshakes held high; optionally pulse a
    // second start (len 7) at cycle inj. Collects observations only.
    task automatic run_burst(input logic [4:0] l, input int inj,
                             output int n_we, output int n_re, output int n_done,
                             output int done_at, output int max_lvl,
                             output logic err_c1);
        @(negedge clock);
        start = 1'b1; len = l; src_valid = 1'b1; dst_ready = 1'b1;
        n_we = 0; n_re = 0; n_done = 0; done_at = -1; max_lvl = 0; err_c1 = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clock);
            start = (c == inj);
            len   = (c == inj) ? 5'd7 : 5'd0;
            #1;
            if (c == 1) err_c1 = len_err;
            if (we) n_we++;
            if (re) n_re++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c > done_at + 5) break;
        end
        start = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({we, re, busy, done, len_err, level} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs got we/re/busy/done/len_err/level=%b required all 0",
                     {we, re, busy, done, len_err, level});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [0:10] e_we   = 11'b01111000000;
        logic [0:10] e_re   = 11'b00000111100;
        logic [0:10] e_busy = 11'b01111111100;
        logic [0:10] e_done = 11'b00000000010;
        int          e_lvl [11] = '{0, 0, 1, 2, 3, 4, 3, 2, 1, 0, 0};
        @(negedge clock);
        start = 1'b1; len = 5'd4; src_valid = 1'b1; dst_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) begin
                @(negedge clock);
                start = 1'b0;
            end
            #1;
            checks++;
            if ({we, re, busy, done} !== {e_we[c], e_re[c], e_busy[c], e_done[c]}) begin
                failures++;
                $display("FAIL basic_ctrl cyc=%0d got we/re/busy/done=%b required %b", c,
                         {we, re, busy, done}, {e_we[c], e_re[c], e_busy[c], e_done[c]});
            end
            checks++;
            if (level !== 5'(e_lvl[c])) begin
                failures++;
                $display("FAIL basic_level cyc=%0d got %0d required %0d", c, level, e_lvl[c]);
            end
        end
        src_valid = 1'b0; dst_ready = 1'b0;
    endtask

    task automatic test_stalls;
        logic [0:12] sv     = 13'b0101011111100;
        logic [0:12] dr     = 13'b1111110011100;
        logic [0:12] e_we   = 13'b0101010000000;
        logic [0:12] e_re   = 13'b0000000011100;
        logic [0:12] e_busy = 13'b0111111111100;
        logic [0:12] e_done = 13'b0000000000010;
        int n_we = 0;
        int n_re = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clock);
            start = (c == 0); len = 5'd3; src_valid = sv[c]; dst_ready = dr[c];
            #1;
            if (we) n_we++;
            if (re) n_re++;
            checks++;
            if ({we, re, busy, done} !== {e_we[c], e_re[c], e_busy[c], e_done[c]}) begin
                failures++;
                $display("FAIL stall_ctrl cyc=%0d got we/re/busy/done=%b required %b", c,
                         {we, re, busy, done}, {e_we[c], e_re[c], e_busy[c], e_done[c]});
            end
        end
        checks++;
        if (n_we != 3 || n_re != 3) begin
            failures++;
            $display("FAIL stall_counts got we=%0d re=%0d required 3 and 3", n_we, n_re);
        end
        start = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    endtask

    task automatic test_len_zero;
        int n_en = 0;
        @(negedge clock);
        start = 1'b1; len = 5'd0; src_valid = 1'b1; dst_ready = 1'b1;
        #1;
        if (we || re) n_en++;
        @(negedge clock);
        start = 1'b0;
        #1;
        if (we || re) n_en++;
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL len0_done got done/busy=%b required 10", {done, busy});
        end
        @(negedge clock);
        #1;
        if (we || re) n_en++;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL len0_done_width got done=%b required 0", done);
        end
        checks++;
        if (n_en != 0) begin
            failures++;
            $display("FAIL len0_no_enables got %0d enable cycles required 0", n_en);
        end
        src_valid = 1'b0; dst_ready = 1'b0;
    endtask

    task automatic test_len_over;
        int n_we, n_re, n_done, done_at, max_lvl;
        logic err_c1;
        run_burst(5'd20, -1, n_we, n_re, n_done, done_at, max_lvl, err_c1);
        checks++;
        if (n_we != 16 || n_re != 16 || n_done != 1) begin
            failures++;
            $display("FAIL len20_counts got we=%0d re=%0d done=%0d required 16 16 1",
                     n_we, n_re, n_done);
        end
        checks++;
        if (max_lvl != 16 || level !== 5'd0) begin
            failures++;
            $display("FAIL len20_level got peak=%0d end=%0d required 16 and 0", max_lvl, level);
        end
        checks++;
        if (err_c1 !== 1'b1 || len_err !== 1'b1) begin
            failures++;
            $display("FAIL len20_err got %b/%b required sticky 1", err_c1, len_err);
        end
        run_burst(5'd2, -1, n_we, n_re, n_done, done_at, max_lvl, err_c1);
        checks++;
        if (err_c1 !== 1'b0 || n_we != 2 || n_re != 2) begin
            failures++;
            $display("FAIL len2_after_err got err=%b we=%0d re=%0d required 0 2 2",
                     err_c1, n_we, n_re);
        end
    endtask

    task automatic test_mid_reset;
        int n_we, n_re, n_done, done_at, max_lvl;
        logic err_c1;
        @(negedge clock);
        start = 1'b1; len = 5'd5; src_valid = 1'b1; dst_ready = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({we, re, busy, done, len_err, level} !== 10'b0) begin
            failures++;
            $display("FAIL midreset_outputs got we/re/busy/done/len_err/level=%b required all 0",
                     {we, re, busy, done, len_err, level});
        end
        @(negedge clock);
        reset = 1'b0;
        run_burst(5'd1, -1, n_we, n_re, n_done, done_at, max_lvl, err_c1);
        checks++;
        if (n_we != 1 || n_re != 1 || done_at != 3) begin
            failures++;
            $display("FAIL midreset_len1 got we=%0d re=%0d done_at=%0d required 1 1 3",
                     n_we, n_re, done_at);
        end
    endtask

    task automatic test_start_ignored;
        int n_we, n_re, n_done, done_at, max_lvl;
        logic err_c1;
        run_burst(5'd4, 6, n_we, n_re, n_done, done_at, max_lvl, err_c1);
        checks++;
        if (n_we != 4 || n_re != 4 || n_done != 1 || done_at != 9) begin
            failures++;
            $display("FAIL busy_start got we=%0d re=%0d done=%0d at %0d required 4 4 1 at 9",
                     n_we, n_re, n_done, done_at);
        end
        #1;
        checks++;
        if (busy !== 1'b0 || level !== 5'd0) begin
            failures++;
            $display("FAIL busy_start_idle got busy=%b level=%0d required 0 0", busy, level);
        end
    endtask

`ifdef ENC_FIFO_SEQ_ABORT_EN
    task automatic test_abort;
        int n_flush = 0;
        int n_done  = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            start     = (c == 0);
            len       = 5'd4;
            src_valid = 1'b1;
            dst_ready = (c != 6);
            abort     = (c == 6);
            #1;
            if (flush) n_flush++;
            if (done)  n_done++;
            if (c == 7) begin
                checks++;
                if ({busy, flush, level} !== {1'b0, 1'b1, 5'd0}) begin
                    failures++;
                    $display("FAIL abort_next got busy/flush/level=%b required 0 1 00000",
                             {busy, flush, level});
                end
            end
        end
        checks++;
        if (n_flush != 1 || n_done != 0) begin
            failures++;
            $display("FAIL abort_pulses got flush=%0d done=%0d required 1 0", n_flush, n_done);
        end
        abort = 1'b0; src_valid = 1'b0; dst_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = 5'd0; src_valid = 1'b0; dst_ready = 1'b0;
`ifdef ENC_FIFO_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stalls();
        test_len_zero();
        test_len_over();
        test_mid_reset();
        test_start_ignored();
`ifdef ENC_FIFO_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
